// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared definitions for the instruction-fetch front end: machine
//            width, instruction size, the buffered {pc, instr} entry and the
//            canonical NOP encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0 - reserved for bubble insertion in a later revision
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Small synchronous FIFO of fetch entries with single-cycle flush.
//            A push into a full buffer is accepted only when a pop happens in
//            the same cycle (occupancy then stays unchanged).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_flush        - drop all entries (wins over push/pop)
//            i_push, i_data - enqueue i_data
//            i_pop          - dequeue head
//            o_head         - head entry; last presented head while empty
//            o_full,o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    fetch_entry_t             r_mem [DEPTH];
    fetch_entry_t             r_last_head;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_CNT_W-1:0]       r_count;

    logic                     w_do_pop;
    logic                     w_do_push;
    logic                     w_wr_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // The slot freed by a same-cycle pop is the one being written when full.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign w_wr_en   = w_do_push & ~i_flush;

    // While empty the head port keeps showing whatever was last at the head,
    // so downstream sees no spurious toggling on the data lines.
    assign o_head = o_empty ? r_last_head : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_last_head <= '0;
        end else begin
            if ((i_flush | i_pop) & ~o_empty) begin
                r_last_head <= r_mem[r_rd_ptr];
            end
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                unique case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch controller. Owns the PC, addresses a
//            combinational-read instruction memory, buffers {pc, instr} pairs
//            and hands them to decode over valid/ready. EX redirects flush the
//            buffer and reload the PC; misaligned targets set a sticky flag.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            fetch_en                  - allow new fetches
//            imem_addr / imem_instr    - instruction memory address / data
//            redirect_valid/_pc        - PC change request from EX
//            out_valid/_ready/_pc/_instr - decode handshake and head entry
//            misalign_err              - sticky misaligned-redirect flag
//            fetched_cnt               - completed decode handshakes
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              XLEN      = fetch_sequencer_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            misalign_err,
    output logic [31:0]     fetched_cnt
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [31:0]     r_fetched_cnt;

    logic            w_pop;
    logic            w_push;
    logic            w_buf_pop;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic [XLEN-1:0] w_redirect_target;

    assign imem_addr = r_pc;

    assign out_valid = ~w_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

    assign w_pop     = out_valid & out_ready;
    // A redirect squashes the handshake: the head is flushed, not delivered.
    assign w_buf_pop = w_pop & ~redirect_valid;
    assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop);

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = imem_instr;

    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_buf_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetched_cnt <= '0;
        end else if (w_buf_pop) begin
            r_fetched_cnt <= r_fetched_cnt + 32'd1;
        end
    end

    assign misalign_err = r_misalign;
    assign fetched_cnt  = r_fetched_cnt;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. A queue-based reference
//            model tracks the expected PC, buffer contents, error flag and
//            delivered count; directed scenarios add literal expectations.
//            A second instance exercises a high RESET_PC for address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] c_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC_HI = 32'hFFFF_FFF8;
    localparam int          c_DEPTH       = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_err;
    logic [31:0] fetched_cnt;

    logic        hi_fetch_en = 1'b0;
    logic        hi_redirect_valid = 1'b0;
    logic [31:0] hi_redirect_pc = '0;
    logic        hi_out_ready = 1'b1;
    logic [31:0] hi_imem_addr;
    logic [31:0] hi_imem_instr;
    logic        hi_out_valid;
    logic [31:0] hi_out_pc;
    logic [31:0] hi_out_instr;
    logic        hi_misalign_err;
    logic [31:0] hi_fetched_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_cnt;
    bit          m_live = 1'b0;
    bit          m_pop;
    bit          m_push;
    ent_t        m_ent;

    // Instruction memory image: word i holds 0x1000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    assign imem_instr    = mem_word(imem_addr);
    assign hi_imem_instr = mem_word(hi_imem_addr);

    fetch_sequencer #(
        .XLEN      (32),
        .RESET_PC  (c_RESET_PC),
        .BUF_DEPTH (c_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err),
        .fetched_cnt    (fetched_cnt)
    );

    fetch_sequencer #(
        .XLEN      (32),
        .RESET_PC  (c_RESET_PC_HI),
        .BUF_DEPTH (c_DEPTH)
    ) dut_hi (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (hi_fetch_en),
        .imem_addr      (hi_imem_addr),
        .imem_instr     (hi_imem_instr),
        .redirect_valid (hi_redirect_valid),
        .redirect_pc    (hi_redirect_pc),
        .out_valid      (hi_out_valid),
        .out_ready      (hi_out_ready),
        .out_pc         (hi_out_pc),
        .out_instr      (hi_out_instr),
        .misalign_err   (hi_misalign_err),
        .fetched_cnt    (hi_fetched_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: evaluated on each rising edge from the same inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_pc   = c_RESET_PC;
                m_err  = 1'b0;
                m_cnt  = '0;
                m_live = 1'b1;
            end else if (m_live) begin
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc = {redirect_pc[31:2], 2'b00};
                    if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
                end else begin
                    m_pop  = (m_q.size() > 0) && out_ready;
                    m_push = fetch_en && ((m_q.size() < c_DEPTH) || m_pop);
                    if (m_pop) begin
                        m_q.delete(0);
                        m_cnt = m_cnt + 32'd1;
                    end
                    if (m_push) begin
                        m_ent.pc    = m_pc;
                        m_ent.instr = mem_word(m_pc);
                        m_q.push_back(m_ent);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("model_imem_addr", imem_addr, m_pc);
                chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
                if (m_q.size() != 0) begin
                    chk("model_out_pc", out_pc, m_q[0].pc);
                    chk("model_out_instr", out_instr, m_q[0].instr);
                end
                chk("model_misalign", {31'b0, misalign_err}, {31'b0, m_err});
                chk("model_fetched_cnt", fetched_cnt, m_cnt);
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_cnt", fetched_cnt, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);

        // Streaming with decode always ready
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        chk("stream_first_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_first_pc", out_pc, 32'h0);
        chk("stream_first_instr", out_instr, 32'h1000);
        chk("stream_first_addr", imem_addr, 32'h4);
        repeat (3) tick();
        chk("stream_pc", out_pc, 32'hC);
        chk("stream_instr", out_instr, 32'h1003);
        chk("stream_cnt", fetched_cnt, 32'd3);
        chk("stream_addr", imem_addr, 32'h10);

        // Decode stalled from the start: buffer fills with pc 0 and 4
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("stall_addr_2", imem_addr, 32'h8);
        chk("stall_pc_2", out_pc, 32'h0);
        repeat (3) tick();
        chk("stall_addr_5", imem_addr, 32'h8);
        chk("stall_pc_5", out_pc, 32'h0);
        chk("stall_instr_5", out_instr, 32'h1000);
        chk("stall_cnt_5", fetched_cnt, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("resume_pc_1", out_pc, 32'h4);
        chk("resume_instr_1", out_instr, 32'h1001);
        tick();
        chk("resume_pc_2", out_pc, 32'h8);
        chk("resume_cnt_2", fetched_cnt, 32'd2);

        // Redirect while full and decode ready
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("redir_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_cnt", fetched_cnt, 32'd2);
        redirect_valid = 1'b0;
        tick();
        chk("redir_next_pc", out_pc, 32'h100);
        chk("redir_next_instr", out_instr, 32'h1040);

        // Misaligned redirect sets a sticky flag
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_cnt", fetched_cnt, 32'd2);
        redirect_valid = 1'b0;
        repeat (10) tick();
        chk("mis_err_held", {31'b0, misalign_err}, 32'd1);
        chk("mis_cnt_after", fetched_cnt, 32'd11);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("mis_err_aligned", {31'b0, misalign_err}, 32'd1);
        chk("mis_aligned_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;

        // Fill two entries, then drain with fetch disabled
        out_ready = 1'b0;
        tick();
        tick();
        fetch_en = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_addr_frozen", imem_addr, 32'h208);
        chk("drain_cnt", fetched_cnt, 32'd13);

        // Reset mid-stream with two entries buffered
        fetch_en = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_pc", out_pc, 32'h0);
        chk("midrst_instr", out_instr, 32'h0);
        chk("midrst_cnt", fetched_cnt, 32'd0);
        chk("midrst_addr", imem_addr, c_RESET_PC);
        chk("midrst_err", {31'b0, misalign_err}, 32'd0);

        // High reset PC: address wraps through zero
        rst = 1'b0; hi_fetch_en = 1'b1;
        tick();
        chk("hi_pc_0", hi_out_pc, 32'hFFFF_FFF8);
        chk("hi_instr_0", hi_out_instr, 32'h4000_0FFE);
        tick();
        chk("hi_pc_1", hi_out_pc, 32'hFFFF_FFFC);
        chk("hi_instr_1", hi_out_instr, 32'h4000_0FFF);
        chk("hi_addr_wrap", hi_imem_addr, 32'h0);
        tick();
        chk("hi_pc_2", hi_out_pc, 32'h0);
        chk("hi_instr_2", hi_out_instr, 32'h1000);
        tick();
        chk("hi_pc_3", hi_out_pc, 32'h4);
        chk("hi_instr_3", hi_out_instr, 32'h1001);
        chk("hi_cnt", hi_fetched_cnt, 32'd3);
        chk("hi_err", {31'b0, hi_misalign_err}, 32'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
